// File: rtl/fifo_rd_drain_if.sv
// fifo_rd_drain_if: FIFO read side plus downstream valid/ready stream.
// master = drain block, slave = FIFO/consumer side.
interface fifo_rd_drain_if #(
  parameter int DATA_W = 128
);
  logic              o_rden;
  logic              i_empty;
  logic [DATA_W-1:0] i_rddata;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              i_ready;

  modport master (
    output o_rden,
    input  i_empty,
    input  i_rddata,
    output o_valid,
    output o_data,
    input  i_ready
  );

  modport slave (
    input  o_rden,
    output i_empty,
    output i_rddata,
    input  o_valid,
    input  o_data,
    output i_ready
  );
endinterface

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: pops a latency-1 FIFO into a 2-entry registered skid
// buffer and streams it out. Ports: clk, rstn (async, active high),
// i_en, bus (FIFO rd + stream), o_busy, o_count (transfer counter).
module fifo_rd_drain #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_en,
  fifo_rd_drain_if.master  bus,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       pop;
  logic       cap;
  logic       rden;
  logic [1:0] fill;

  assign pop = (occ_q != 2'd0) & bus.i_ready;
  assign cap = inflight_q;

  // Slots committed after this cycle; occ=2 with a read in
  // flight never happens, so this fits in 2 bits.
  assign fill = occ_q + {1'b0, inflight_q} - {1'b0, pop};

  assign rden = (state_q == RUN) & ~bus.i_empty
              & (fill < 2'd2);

  assign inflight_d = rden;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_en) state_d = RUN;
      end
      RUN: begin
        if (!i_en) state_d = FLUSH;
      end
      FLUSH: begin
        if (i_en)
          state_d = RUN;
        else if (!inflight_q && occ_q == 2'd0)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tail write and head pop; when both happen the
  // surviving oldest word moves to head, order kept.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    occ_d  = occ_q + {1'b0, cap} - {1'b0, pop};
    if (cap && pop) begin
      if (occ_q == 2'd2) begin
        head_d = skid_q;
        skid_d = bus.i_rddata;
      end else begin
        head_d = bus.i_rddata;
      end
    end else if (pop) begin
      if (occ_q == 2'd2) head_d = skid_q;
    end else if (cap) begin
      if (occ_q == 2'd0) head_d = bus.i_rddata;
      else               skid_d = bus.i_rddata;
    end
  end

  assign cnt_d = pop ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= '0;
      skid_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.o_rden  = rden;
  assign bus.o_valid = (occ_q != 2'd0);
  assign bus.o_data  = head_q;
  assign o_busy      = inflight_q | (occ_q != 2'd0);
  assign o_count     = cnt_q;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: directed bench for fifo_rd_drain with a
// behavioural latency-1 FIFO and an output scoreboard.
module tb_fifo_rd_drain;

  localparam int DW = 128;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_en;
  logic          o_busy;
  logic [CW-1:0] o_count;

  fifo_rd_drain_if #(.DATA_W(DW)) bus ();

  fifo_rd_drain #(
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .i_en   (i_en),
    .bus    (bus),
    .o_busy (o_busy),
    .o_count(o_count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] fq[$];
  logic [DW-1:0] outq[$];
  logic          rden_n = 1'b0;
  int rden_cnt, run, max_run, xrun, max_xrun;
  int valid_hi, busy_hi, stall_err, und;
  logic          stall_p;
  logic [DW-1:0] data_p;

  // FIFO model: pop decided from o_rden seen mid-cycle,
  // data presented just after the edge, held a full cycle.
  initial begin
    bus.i_empty  = 1'b1;
    bus.i_rddata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rden_n && fq.size() > 0)
        bus.i_rddata = fq.pop_front();
      bus.i_empty = (fq.size() == 0);
    end
  end

  initial und = 0;

  always @(negedge clk) begin
    rden_n = bus.o_rden;
    if (bus.o_rden) begin
      rden_cnt++;
      run++;
      if (run > max_run) max_run = run;
      if (bus.i_empty) und++;
    end else begin
      run = 0;
    end
    if (bus.o_valid) valid_hi++;
    if (o_busy) busy_hi++;
    if (bus.o_valid && bus.i_ready) begin
      outq.push_back(bus.o_data);
      xrun++;
      if (xrun > max_xrun) max_xrun = xrun;
    end else begin
      xrun = 0;
    end
    if (stall_p && (!bus.o_valid || bus.o_data !== data_p))
      stall_err++;
    stall_p = bus.o_valid && !bus.i_ready;
    data_p  = bus.o_data;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    rden_cnt  = 0;
    run       = 0;
    max_run   = 0;
    xrun      = 0;
    max_xrun  = 0;
    valid_hi  = 0;
    busy_hi   = 0;
    stall_err = 0;
    stall_p   = 1'b0;
    outq.delete();
  endtask

  task automatic do_reset();
    rstn        = 1'b1;
    i_en        = 1'b0;
    bus.i_ready = 1'b0;
    fq.delete();
    tick(2);
    rstn = 1'b0;
    tick(1);
    clr();
  endtask

  task automatic preload(input int n);
    for (int i = 1; i <= n; i++) fq.push_back(DW'(i));
    tick(2);
  endtask

  task automatic chk_seq(input string tag, input int n);
    chk({tag, "_n"}, DW'(outq.size()), DW'(n));
    for (int i = 0; i < n && i < outq.size(); i++)
      chk({tag, "_d"}, outq[i], DW'(i + 1));
  endtask

  int found;

  initial begin
    rstn        = 1'b1;
    i_en        = 1'b0;
    bus.i_ready = 1'b0;
    clr();
    #2;
    chk("rst_valid", DW'(bus.o_valid), DW'(0));
    chk("rst_rden",  DW'(bus.o_rden),  DW'(0));
    chk("rst_count", DW'(o_count),     DW'(0));
    chk("rst_busy",  DW'(o_busy),      DW'(0));
    chk("rst_data",  bus.o_data,       DW'(0));

    // streaming 8 words
    do_reset();
    preload(8);
    bus.i_ready = 1'b1;
    i_en = 1'b1;
    tick(20);
    chk("str_rden",  DW'(rden_cnt), DW'(8));
    chk("str_run",   DW'(max_run),  DW'(8));
    chk("str_xrun",  DW'(max_xrun), DW'(8));
    chk_seq("str", 8);
    chk("str_count", DW'(o_count),  DW'(8));
    i_en = 1'b0;
    tick(4);
    chk("str_busy",  DW'(o_busy),      DW'(0));
    chk("str_idle",  DW'(dut.state_q), DW'(0));

    // backpressure
    do_reset();
    preload(4);
    i_en = 1'b1;
    tick(10);
    chk("bp_rden",  DW'(rden_cnt),  DW'(2));
    chk("bp_valid", DW'(bus.o_valid), DW'(1));
    chk("bp_data",  bus.o_data,     DW'(1));
    chk("bp_busy",  DW'(o_busy),    DW'(1));
    chk("bp_hold",  DW'(stall_err), DW'(0));
    bus.i_ready = 1'b1;
    tick(10);
    chk_seq("bp", 4);
    chk("bp_rden2", DW'(rden_cnt),  DW'(4));

    // empty FIFO, enabled
    do_reset();
    bus.i_ready = 1'b1;
    i_en = 1'b1;
    tick(20);
    chk("emp_rden",  DW'(rden_cnt), DW'(0));
    chk("emp_valid", DW'(valid_hi), DW'(0));
    chk("emp_busy",  DW'(busy_hi),  DW'(0));

    // flush: drop i_en in the cycle of an o_rden pulse
    do_reset();
    preload(4);
    bus.i_ready = 1'b1;
    i_en = 1'b1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.o_rden) begin
        found = 1;
        break;
      end
    end
    i_en = 1'b0;
    clr();
    tick(10);
    chk("fl_found", DW'(found),       DW'(1));
    chk("fl_rden",  DW'(rden_cnt),    DW'(1));
    chk_seq("fl", 1);
    chk("fl_busy",  DW'(o_busy),      DW'(0));
    chk("fl_idle",  DW'(dut.state_q), DW'(0));

    // reset mid-stream with 2 words buffered
    do_reset();
    preload(8);
    bus.i_ready = 1'b1;
    i_en = 1'b1;
    tick(4);
    bus.i_ready = 1'b0;
    tick(3);
    chk("mr_pcount", DW'(o_count),   DW'(1));
    chk("mr_pvalid", DW'(bus.o_valid), DW'(1));
    rstn = 1'b1;
    #1;
    chk("mr_valid", DW'(bus.o_valid), DW'(0));
    chk("mr_count", DW'(o_count),     DW'(0));
    chk("mr_busy",  DW'(o_busy),      DW'(0));
    chk("mr_data",  bus.o_data,       DW'(0));
    #1;
    rstn = 1'b0;
    #1;
    chk("mr_rden",  DW'(bus.o_rden),  DW'(0));
    i_en = 1'b0;
    tick(2);

    // counter wrap, 4-bit counter
    do_reset();
    preload(17);
    bus.i_ready = 1'b1;
    i_en = 1'b1;
    tick(30);
    chk("wr_count", DW'(o_count),     DW'(1));
    chk("wr_n",     DW'(outq.size()), DW'(17));
    if (outq.size() == 17)
      chk("wr_last", outq[16], DW'(17));
    i_en = 1'b0;
    tick(4);

    chk("no_underflow", DW'(und), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
